// File: rtl/nl2_dbank_wr_rcv_buf.sv
// Write-data receive buffer feeding the data-bank write controller.
// Holds write beats (data + byte mask) in a small circular FIFO, flags
// partial-mask beats that need read-modify-write, and merges the bank
// read data into the head beat while the controller performs the RMW read.
module nl2_dbank_wr_rcv_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int N_SRAM     = 4,
    localparam int MASK_WIDTH = DATA_WIDTH / 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  dbank_ctrl_clk,
    input  logic                  rst_a_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_accept,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    output logic                  rcv_valid,
    input  logic                  rcv_accept,
    output logic                  rcv_rmw_req,
    output logic [DATA_WIDTH-1:0] rcv_data,
    output logic [MASK_WIDTH-1:0] rcv_mask,
    input  logic [N_SRAM-1:0]     rmw_rd_data_sel,
    input  logic [DATA_WIDTH-1:0] rmw_rd_data,
    output logic [CNT_W-1:0]      rcv_count,
    output logic                  rmw_err
);

    typedef enum logic {
        IDLE = 1'b0,
        CAPT = 1'b1
    } mstate_t;

    // Expand a byte mask into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [MASK_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            res[i*8 +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

    // Entry storage is intentionally not reset; validity comes from count.
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [MASK_WIDTH-1:0] ent_mask [DEPTH];
    logic                  ent_part [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    mstate_t          mstate;
    mstate_t          mstate_nxt;
    logic             act;

    logic                  full;
    logic                  empty;
    logic                  sel_any;
    logic                  push;
    logic                  pop;
    logic                  start_merge;
    logic                  err_set;
    logic [DATA_WIDTH-1:0] head_bm;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign sel_any     = |rmw_rd_data_sel;
    // act keeps wr_accept low while reset is asserted and for the first edge after.
    assign wr_accept   = act & ~full & ~flush;
    assign rcv_valid   = ~empty & (mstate != CAPT);
    assign push        = wr_valid & wr_accept;
    assign pop         = rcv_accept & rcv_valid;
    assign start_merge = (mstate == IDLE) & sel_any & ~empty;
    assign err_set     = sel_any & empty;
    assign head_bm     = expand_mask(ent_mask[rd_ptr]);

    // Head-beat view; gated so unreset storage never leaks to the outputs.
    assign rcv_data    = rcv_valid ? ent_data[rd_ptr] : '0;
    assign rcv_mask    = rcv_valid ? ent_mask[rd_ptr] : '0;
    assign rcv_rmw_req = rcv_valid & ent_part[rd_ptr];
    assign rcv_count   = count;

    // Merge FSM next-state: one capture cycle per RMW read, flush forces idle.
    always_comb begin
        mstate_nxt = mstate;
        case (mstate)
            IDLE:    if (start_merge) mstate_nxt = CAPT;
            CAPT:    mstate_nxt = IDLE;
            default: mstate_nxt = IDLE;
        endcase
        if (flush) mstate_nxt = IDLE;
    end

    // Merge FSM state register.
    always_ff @(posedge dbank_ctrl_clk or negedge rst_a_n) begin
        if (!rst_a_n) mstate <= IDLE;
        else          mstate <= mstate_nxt;
    end

    // Pointers, occupancy, error flag and the post-reset enable.
    always_ff @(posedge dbank_ctrl_clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rmw_err <= 1'b0;
            act     <= 1'b0;
        end else begin
            act <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                rmw_err <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (err_set) rmw_err <= 1'b1;
            end
        end
    end

    // Entry writes: push at the tail, merge into the head during capture.
    // The two never alias: a push needs a free slot, the head is occupied.
    always_ff @(posedge dbank_ctrl_clk) begin
        if (push) begin
            ent_data[wr_ptr] <= wr_data;
            ent_mask[wr_ptr] <= wr_mask;
            ent_part[wr_ptr] <= ~&wr_mask;
        end
        if ((mstate == CAPT) && !flush) begin
            ent_data[rd_ptr] <= (ent_data[rd_ptr] & head_bm) | (rmw_rd_data & ~head_bm);
            ent_mask[rd_ptr] <= '1;
            ent_part[rd_ptr] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nl2_dbank_wr_rcv_buf.sv
// Self-checking bench for nl2_dbank_wr_rcv_buf (DATA_WIDTH=64, DEPTH=4, N_SRAM=4).
module tb_nl2_dbank_wr_rcv_buf;

    logic        dbank_ctrl_clk;
    logic        rst_a_n;
    logic        flush;
    logic        wr_valid;
    logic        wr_accept;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;
    logic        rcv_valid;
    logic        rcv_accept;
    logic        rcv_rmw_req;
    logic [63:0] rcv_data;
    logic [7:0]  rcv_mask;
    logic [3:0]  rmw_rd_data_sel;
    logic [63:0] rmw_rd_data;
    logic [2:0]  rcv_count;
    logic        rmw_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_data [$];
    logic [7:0]  q_mask [$];

    nl2_dbank_wr_rcv_buf #(.DATA_WIDTH(64), .DEPTH(4), .N_SRAM(4)) dut (
        .dbank_ctrl_clk (dbank_ctrl_clk),
        .rst_a_n        (rst_a_n),
        .flush          (flush),
        .wr_valid       (wr_valid),
        .wr_accept      (wr_accept),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .rcv_valid      (rcv_valid),
        .rcv_accept     (rcv_accept),
        .rcv_rmw_req    (rcv_rmw_req),
        .rcv_data       (rcv_data),
        .rcv_mask       (rcv_mask),
        .rmw_rd_data_sel(rmw_rd_data_sel),
        .rmw_rd_data    (rmw_rd_data),
        .rcv_count      (rcv_count),
        .rmw_err        (rmw_err)
    );

    initial dbank_ctrl_clk = 1'b0;
    always #5 dbank_ctrl_clk = ~dbank_ctrl_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-wise reference merge: keep enabled bytes, fill the rest from read data.
    function automatic logic [63:0] merge_model(input logic [63:0] d, input logic [7:0] m,
                                                input logic [63:0] r);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) res[b*8 +: 8] = m[b] ? d[b*8 +: 8] : r[b*8 +: 8];
        return res;
    endfunction

    task automatic tick();
        @(posedge dbank_ctrl_clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; wr_valid = 0; wr_data = '0; wr_mask = '0;
        rcv_accept = 0; rmw_rd_data_sel = '0; rmw_rd_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_a_n = 0;
        repeat (2) @(posedge dbank_ctrl_clk);
        #2;
        checks++;
        if ({wr_accept, rcv_valid, rcv_rmw_req, rmw_err} !== 4'b0 || rcv_count !== 3'd0 ||
            rcv_data !== 64'd0 || rcv_mask !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: acc=%b vld=%b req=%b err=%b cnt=%0d data=%h mask=%h, want all 0",
                     wr_accept, rcv_valid, rcv_rmw_req, rmw_err, rcv_count, rcv_data, rcv_mask);
        end
        rst_a_n = 1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 64'hD0D0_0000_0000_0000 + 64'(i); wr_mask = 8'hFF;
            #1;
            checks++;
            if (wr_accept !== 1'b1) begin
                errors++; $display("FAIL fill_accept[%0d]: got %b want 1", i, wr_accept);
            end
            q_data.push_back(wr_data); q_mask.push_back(wr_mask);
            tick();
        end
        wr_data = 64'hD0D0_0000_0000_0004;
        #1;
        checks++;
        if (wr_accept !== 1'b0 || rcv_count !== 3'd4 || rcv_valid !== 1'b1 ||
            rcv_data !== q_data[0] || rcv_rmw_req !== 1'b0) begin
            errors++;
            $display("FAIL full_state: acc=%b cnt=%0d vld=%b data=%h req=%b, want acc=0 cnt=4 vld=1 data=%h req=0",
                     wr_accept, rcv_count, rcv_valid, rcv_data, rcv_rmw_req, q_data[0]);
        end
    endtask

    task automatic test_full_pop();
        rcv_accept = 1;
        #1;
        checks++;
        if (rcv_data !== q_data[0] || rcv_mask !== q_mask[0]) begin
            errors++; $display("FAIL full_pop_data: got %h/%h want %h/%h", rcv_data, rcv_mask, q_data[0], q_mask[0]);
        end
        void'(q_data.pop_front()); void'(q_mask.pop_front());
        tick();
        rcv_accept = 0;
        #1;
        checks++;
        if (rcv_count !== 3'd3 || wr_accept !== 1'b1) begin
            errors++; $display("FAIL full_pop_count: cnt=%0d acc=%b want cnt=3 acc=1", rcv_count, wr_accept);
        end
        q_data.push_back(wr_data); q_mask.push_back(wr_mask);
        tick();
        wr_valid = 0;
        #1;
        checks++;
        if (rcv_count !== 3'd4) begin
            errors++; $display("FAIL refill_count: got %0d want 4", rcv_count);
        end
        rcv_accept = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rcv_valid !== 1'b1 || rcv_data !== q_data[0]) begin
                errors++; $display("FAIL drain[%0d]: vld=%b data=%h want vld=1 data=%h", i, rcv_valid, rcv_data, q_data[0]);
            end
            void'(q_data.pop_front()); void'(q_mask.pop_front());
            tick();
        end
        rcv_accept = 0;
        #1;
        checks++;
        if (rcv_count !== 3'd0 || rcv_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: cnt=%0d vld=%b want 0/0", rcv_count, rcv_valid);
        end
    endtask

    task automatic test_rmw_merge();
        logic [63:0] rd;
        // Directed merge, then a zero-mask merge with sel held during capture.
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1;
            wr_data  = (k == 0) ? 64'h1111_1111_1111_1111 : {$urandom, $urandom};
            wr_mask  = (k == 0) ? 8'h0F : 8'h00;
            rd       = (k == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : {$urandom, $urandom};
            q_data.push_back(wr_data); q_mask.push_back(wr_mask);
            tick();
            wr_valid = 0; rmw_rd_data_sel = (k == 0) ? 4'b0010 : 4'b1000;
            #1;
            checks++;
            if (rcv_rmw_req !== 1'b1 || rcv_valid !== 1'b1) begin
                errors++; $display("FAIL rmw_req_before[%0d]: req=%b vld=%b want 1/1", k, rcv_rmw_req, rcv_valid);
            end
            tick();
            if (k == 0) rmw_rd_data_sel = '0;
            rmw_rd_data = rd;
            #1;
            checks++;
            if (rcv_valid !== 1'b0) begin
                errors++; $display("FAIL capt_valid[%0d]: got %b want 0", k, rcv_valid);
            end
            q_data[0] = merge_model(q_data[0], q_mask[0], rd);
            q_mask[0] = 8'hFF;
            tick();
            rmw_rd_data_sel = '0; rmw_rd_data = '0;
            #1;
            checks++;
            if (k == 0 && rcv_data !== 64'hAAAA_AAAA_1111_1111) begin
                errors++; $display("FAIL merge_const: got %h want aaaaaaaa11111111", rcv_data);
            end
            checks++;
            if (rcv_valid !== 1'b1 || rcv_data !== q_data[0] || rcv_mask !== 8'hFF || rcv_rmw_req !== 1'b0) begin
                errors++;
                $display("FAIL merge_after[%0d]: vld=%b data=%h mask=%h req=%b want vld=1 data=%h mask=ff req=0",
                         k, rcv_valid, rcv_data, rcv_mask, rcv_rmw_req, q_data[0]);
            end
            rcv_accept = 1;
            tick();
            void'(q_data.pop_front()); void'(q_mask.pop_front());
            rcv_accept = 0;
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1; wr_data = {$urandom, $urandom}; wr_mask = 8'hFF;
        q_data.push_back(wr_data); q_mask.push_back(wr_mask);
        tick();
        for (int i = 0; i < 20; i++) begin
            wr_data = {$urandom, $urandom};
            wr_mask = (i % 3 == 0) ? 8'(1 << (i % 8)) : 8'hFF;
            rcv_accept = 1;
            #1;
            checks++;
            if (wr_accept !== 1'b1 || rcv_count !== 3'd1 || rcv_data !== q_data[0] ||
                rcv_mask !== q_mask[0] || rcv_rmw_req !== ~&q_mask[0]) begin
                errors++;
                $display("FAIL b2b[%0d]: acc=%b cnt=%0d data=%h mask=%h req=%b want acc=1 cnt=1 data=%h mask=%h req=%b",
                         i, wr_accept, rcv_count, rcv_data, rcv_mask, rcv_rmw_req, q_data[0], q_mask[0], ~&q_mask[0]);
            end
            void'(q_data.pop_front()); void'(q_mask.pop_front());
            q_data.push_back(wr_data); q_mask.push_back(wr_mask);
            tick();
        end
        wr_valid = 0;
        #1;
        checks++;
        if (rcv_data !== q_data[0] || rcv_count !== 3'd1) begin
            errors++; $display("FAIL b2b_last: data=%h cnt=%0d want %h 1", rcv_data, rcv_count, q_data[0]);
        end
        void'(q_data.pop_front()); void'(q_mask.pop_front());
        tick();
        rcv_accept = 0;
        #1;
        checks++;
        if (rcv_count !== 3'd0) begin
            errors++; $display("FAIL b2b_empty: cnt=%0d want 0", rcv_count);
        end
    endtask

    task automatic test_err_flush();
        rmw_rd_data_sel = 4'b0001;
        tick();
        rmw_rd_data_sel = '0;
        #1;
        checks++;
        if (rmw_err !== 1'b1 || rcv_valid !== 1'b0 || rcv_count !== 3'd0) begin
            errors++; $display("FAIL err_set: err=%b vld=%b cnt=%0d want 1 0 0", rmw_err, rcv_valid, rcv_count);
        end
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1; wr_data = 64'hF1F1_0000_0000_0000 + 64'(i); wr_mask = 8'hFF;
            tick();
        end
        checks++;
        if (rmw_err !== 1'b1 || rcv_count !== 3'd2) begin
            errors++; $display("FAIL err_sticky: err=%b cnt=%0d want 1 2", rmw_err, rcv_count);
        end
        flush = 1; rcv_accept = 1;
        #1;
        checks++;
        if (wr_accept !== 1'b0) begin
            errors++; $display("FAIL flush_accept: got %b want 0", wr_accept);
        end
        tick();
        flush = 0; wr_valid = 0; rcv_accept = 0;
        #1;
        checks++;
        if (rmw_err !== 1'b0 || rcv_count !== 3'd0 || rcv_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: err=%b cnt=%0d vld=%b want 0 0 0", rmw_err, rcv_count, rcv_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = 64'hC0C0_0000_0000_0000 + 64'(i); wr_mask = 8'h3C;
            tick();
        end
        wr_valid = 0; rmw_rd_data_sel = 4'b0100;
        tick();
        rmw_rd_data_sel = '0;
        #1;
        checks++;
        if (rcv_valid !== 1'b0 || rcv_count !== 3'd3) begin
            errors++; $display("FAIL pre_reset_capt: vld=%b cnt=%0d want 0 3", rcv_valid, rcv_count);
        end
        rst_a_n = 0;
        #1;
        checks++;
        if ({wr_accept, rcv_valid, rcv_rmw_req, rmw_err} !== 4'b0 || rcv_count !== 3'd0 ||
            rcv_data !== 64'd0 || rcv_mask !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: acc=%b vld=%b req=%b err=%b cnt=%0d data=%h mask=%h, want all 0",
                     wr_accept, rcv_valid, rcv_rmw_req, rmw_err, rcv_count, rcv_data, rcv_mask);
        end
        tick();
        rst_a_n = 1;
        tick();
        wr_valid = 1; wr_data = 64'h0123_4567_89AB_CDEF; wr_mask = 8'hFF;
        #1;
        checks++;
        if (wr_accept !== 1'b1) begin
            errors++; $display("FAIL post_reset_accept: got %b want 1", wr_accept);
        end
        tick();
        wr_valid = 0;
        #1;
        checks++;
        if (rcv_valid !== 1'b1 || rcv_count !== 3'd1 || rcv_data !== 64'h0123_4567_89AB_CDEF || rcv_rmw_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_beat: vld=%b cnt=%0d data=%h req=%b want 1 1 0123456789abcdef 0",
                     rcv_valid, rcv_count, rcv_data, rcv_rmw_req);
        end
    endtask

    initial begin
        rst_a_n = 0;
        test_reset();
        test_fill();
        test_full_pop();
        test_rmw_merge();
        test_back_to_back();
        test_err_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
